network_rx: RTL and testbench

- Responder end of the vanilla-core remote-request protocol.
- Accepts incoming remote requests (load, store, AMO swap/or/add) addressed to this tile, performs them on the local data memory, and builds one return packet per request: credit for stores, writeback for loads and AMOs.
- Sits between the tile's network-link request FIFO and the DMEM arbiter.
- Its return packets reach the requester's return path, which consumes `e_return_*` types.

---
 rtl/network_rx.sv | 191 +++++++++++++++++++
 tb/tb_network_rx.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/network_rx.sv
// Responder end of the remote-request protocol: applies incoming load, store and
// AMO requests to the local DMEM and returns one credit or writeback packet per request.
module network_rx #(
   parameter int data_width_p   = 32,
   parameter int addr_width_p   = 28,
   parameter int x_cord_width_p = 7,
   parameter int y_cord_width_p = 7,
   parameter int dmem_size_p    = 1024,
   localparam int dmem_addr_width_lp = (dmem_size_p > 1) ? $clog2(dmem_size_p) : 1,
   localparam int mask_width_lp      = data_width_p / 8
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,

   input  logic                          in_v_i,
   output logic                          in_yumi_o,
   input  logic [2:0]                    in_op_i,
   input  logic [addr_width_p-1:0]       in_addr_i,
   input  logic [data_width_p-1:0]       in_data_i,
   input  logic [mask_width_lp-1:0]      in_mask_i,
   input  logic [4:0]                    in_reg_id_i,
   input  logic                          in_float_wb_i,
   input  logic                          in_icache_fetch_i,
   input  logic [x_cord_width_p-1:0]     in_src_x_i,
   input  logic [y_cord_width_p-1:0]     in_src_y_i,

   output logic                          dmem_v_o,
   output logic                          dmem_w_o,
   output logic [dmem_addr_width_lp-1:0] dmem_addr_o,
   output logic [data_width_p-1:0]       dmem_data_o,
   output logic [mask_width_lp-1:0]      dmem_mask_o,
   input  logic                          dmem_yumi_i,
   input  logic [data_width_p-1:0]       dmem_data_i,

   output logic                          ret_v_o,
   input  logic                          ret_ready_i,
   output logic [1:0]                    ret_pkt_type_o,
   output logic [data_width_p-1:0]       ret_data_o,
   output logic [4:0]                    ret_reg_id_o,
   output logic [x_cord_width_p-1:0]     ret_x_o,
   output logic [y_cord_width_p-1:0]     ret_y_o,

   output logic                          bad_req_o
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, AMO_WR, RESP} state_e;

   localparam logic [2:0] OpLoad    = 3'd0;
   localparam logic [2:0] OpStore   = 3'd1;
   localparam logic [2:0] OpAmoSwap = 3'd2;
   localparam logic [2:0] OpAmoOr   = 3'd3;
   localparam logic [2:0] OpAmoAdd  = 3'd4;

   localparam logic [addr_width_p:0] DmemSizeLp = (addr_width_p+1)'(dmem_size_p);

   state_e                          state_q, state_d;
   logic [2:0]                      op_q, op_d;
   logic [dmem_addr_width_lp-1:0]   addr_q, addr_d;
   logic [data_width_p-1:0]         operand_q, operand_d;
   logic [data_width_p-1:0]         retData_q, retData_d;
   logic [1:0]                      retType_q, retType_d;
   logic [4:0]                      regId_q, regId_d;
   logic [x_cord_width_p-1:0]       x_q, x_d;
   logic [y_cord_width_p-1:0]       y_q, y_d;

   logic                            isBad;
   logic [1:0]                      acceptType;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= IDLE;
         op_q      <= '0;
         addr_q    <= '0;
         operand_q <= '0;
         retData_q <= '0;
         retType_q <= '0;
         regId_q   <= '0;
         x_q       <= '0;
         y_q       <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         operand_q <= operand_d;
         retData_q <= retData_d;
         retType_q <= retType_d;
         regId_q   <= regId_d;
         x_q       <= x_d;
         y_q       <= y_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      addr_d      = addr_q;
      operand_d   = operand_q;
      retData_d   = retData_q;
      retType_d   = retType_q;
      regId_d     = regId_q;
      x_d         = x_q;
      y_d         = y_q;
      in_yumi_o   = 1'b0;
      bad_req_o   = 1'b0;
      dmem_v_o    = 1'b0;
      dmem_w_o    = 1'b0;
      dmem_addr_o = '0;
      dmem_data_o = '0;
      dmem_mask_o = '0;

      isBad = ({1'b0, in_addr_i} >= DmemSizeLp) || (in_op_i > OpAmoAdd);

      // Response type is fixed at accept time, so bad loads/AMOs still get a writeback type
      unique case (in_op_i)
         OpLoad:                       acceptType = in_icache_fetch_i ? 2'd3 :
                                                    in_float_wb_i     ? 2'd2 : 2'd1;
         OpAmoSwap, OpAmoOr, OpAmoAdd: acceptType = 2'd1;
         default:                      acceptType = 2'd0;
      endcase

      unique case (state_q)
         IDLE: begin
            dmem_w_o    = (in_op_i == OpStore);
            dmem_addr_o = in_addr_i[dmem_addr_width_lp-1:0];
            dmem_data_o = in_data_i;
            dmem_mask_o = (in_op_i == OpStore) ? in_mask_i : '1;
            if (in_v_i) begin
               if (isBad) begin
                  in_yumi_o = 1'b1;
                  bad_req_o = 1'b1;
                  state_d   = RESP;
               end else begin
                  dmem_v_o  = 1'b1;
                  in_yumi_o = dmem_yumi_i;
                  if (dmem_yumi_i) state_d = (in_op_i == OpStore) ? RESP : RD_WAIT;
               end
            end
            if (in_yumi_o) begin
               op_d      = in_op_i;
               addr_d    = in_addr_i[dmem_addr_width_lp-1:0];
               operand_d = in_data_i;
               retData_d = '0;
               retType_d = acceptType;
               regId_d   = in_reg_id_i;
               x_d       = in_src_x_i;
               y_d       = in_src_y_i;
            end
         end
         RD_WAIT: begin
            retData_d = dmem_data_i;
            unique case (op_q)
               OpAmoOr:  operand_d = operand_q | dmem_data_i;
               OpAmoAdd: operand_d = operand_q + dmem_data_i;
               default:  operand_d = operand_q;
            endcase
            state_d = (op_q == OpLoad) ? RESP : AMO_WR;
         end
         AMO_WR: begin
            dmem_v_o    = 1'b1;
            dmem_w_o    = 1'b1;
            dmem_addr_o = addr_q;
            dmem_data_o = operand_q;
            dmem_mask_o = '1;
            if (dmem_yumi_i) state_d = RESP;
         end
         RESP: begin
            if (ret_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Combinational outputs must read zero while reset is asserted
      if (!reset_n_i) begin
         in_yumi_o   = 1'b0;
         bad_req_o   = 1'b0;
         dmem_v_o    = 1'b0;
         dmem_w_o    = 1'b0;
         dmem_addr_o = '0;
         dmem_data_o = '0;
         dmem_mask_o = '0;
      end
   end

   assign ret_v_o        = (state_q == RESP);
   assign ret_pkt_type_o = retType_q;
   assign ret_data_o     = retData_q;
   assign ret_reg_id_o   = regId_q;
   assign ret_x_o        = x_q;
   assign ret_y_o        = y_q;

endmodule

// File: tb/tb_network_rx.sv
// Self-checking bench for network_rx: constant vector table, hand-written corner
// sequences, then random requests compared against a transaction-level memory model.
module tb_network_rx;

   localparam int DW  = 32;
   localparam int AW  = 28;
   localparam int XW  = 7;
   localparam int YW  = 7;
   localparam int DS  = 1024;
   localparam int MW  = DW / 8;
   localparam int DAW = 10;

   logic           clk_i = 1'b0;
   logic           reset_n_i;
   logic           in_v_i;
   logic           in_yumi_o;
   logic [2:0]     in_op_i;
   logic [AW-1:0]  in_addr_i;
   logic [DW-1:0]  in_data_i;
   logic [MW-1:0]  in_mask_i;
   logic [4:0]     in_reg_id_i;
   logic           in_float_wb_i;
   logic           in_icache_fetch_i;
   logic [XW-1:0]  in_src_x_i;
   logic [YW-1:0]  in_src_y_i;
   logic           dmem_v_o;
   logic           dmem_w_o;
   logic [DAW-1:0] dmem_addr_o;
   logic [DW-1:0]  dmem_data_o;
   logic [MW-1:0]  dmem_mask_o;
   logic           dmem_yumi_i;
   logic [DW-1:0]  dmem_data_i;
   logic           ret_v_o;
   logic           ret_ready_i;
   logic [1:0]     ret_pkt_type_o;
   logic [DW-1:0]  ret_data_o;
   logic [4:0]     ret_reg_id_o;
   logic [XW-1:0]  ret_x_o;
   logic [YW-1:0]  ret_y_o;
   logic           bad_req_o;

   network_rx #(
      .data_width_p(DW), .addr_width_p(AW), .x_cord_width_p(XW),
      .y_cord_width_p(YW), .dmem_size_p(DS)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .in_v_i(in_v_i), .in_yumi_o(in_yumi_o), .in_op_i(in_op_i), .in_addr_i(in_addr_i),
      .in_data_i(in_data_i), .in_mask_i(in_mask_i), .in_reg_id_i(in_reg_id_i),
      .in_float_wb_i(in_float_wb_i), .in_icache_fetch_i(in_icache_fetch_i),
      .in_src_x_i(in_src_x_i), .in_src_y_i(in_src_y_i),
      .dmem_v_o(dmem_v_o), .dmem_w_o(dmem_w_o), .dmem_addr_o(dmem_addr_o),
      .dmem_data_o(dmem_data_o), .dmem_mask_o(dmem_mask_o), .dmem_yumi_i(dmem_yumi_i),
      .dmem_data_i(dmem_data_i),
      .ret_v_o(ret_v_o), .ret_ready_i(ret_ready_i), .ret_pkt_type_o(ret_pkt_type_o),
      .ret_data_o(ret_data_o), .ret_reg_id_o(ret_reg_id_o), .ret_x_o(ret_x_o),
      .ret_y_o(ret_y_o), .bad_req_o(bad_req_o)
   );

   always #5 clk_i = ~clk_i;

   // Environment DMEM: granted writes merge by byte mask, granted reads return next cycle
   logic [DW-1:0]  dmemArr [DS];
   logic           memClr;
   int             wrCount = 0;
   logic [DW-1:0]  lastWrData;
   logic [MW-1:0]  lastWrMask;

   always @(posedge clk_i) begin
      if (memClr) begin
         for (int i = 0; i < DS; i++) dmemArr[i] <= '0;
      end else if (dmem_v_o && dmem_yumi_i) begin
         if (dmem_w_o) begin
            for (int b = 0; b < MW; b++)
               if (dmem_mask_o[b]) dmemArr[dmem_addr_o][8*b +: 8] <= dmem_data_o[8*b +: 8];
            wrCount    <= wrCount + 1;
            lastWrData <= dmem_data_o;
            lastWrMask <= dmem_mask_o;
         end else begin
            dmem_data_i <= dmemArr[dmem_addr_o];
         end
      end
   end

   typedef struct {
      logic [2:0]    op;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [MW-1:0] mask;
      logic [4:0]    rid;
      logic          fl;
      logic          ic;
      logic [XW-1:0] sx;
      logic [YW-1:0] sy;
      logic [1:0]    expType;
      logic [DW-1:0] expData;
      logic          expBad;
   } vec_t;

   typedef struct {
      logic [1:0]    typ;
      logic [DW-1:0] data;
      logic [4:0]    rid;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      int            badCyc;
      int            dvCyc;
      logic          done;
   } res_t;

   logic [DW-1:0] refMem [DS];
   int totalChecks = 0;
   int badChecks   = 0;

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      totalChecks++;
      if (act !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mkVec(input logic [2:0] op, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] data, input logic [MW-1:0] mask,
                                  input logic [4:0] rid, input logic fl, input logic ic,
                                  input logic [1:0] eT, input logic [DW-1:0] eD, input logic eB);
      vec_t v;
      v.op = op; v.addr = addr; v.data = data; v.mask = mask; v.rid = rid;
      v.fl = fl; v.ic = ic; v.sx = 7'd2; v.sy = 7'd5;
      v.expType = eT; v.expData = eD; v.expBad = eB;
      return v;
   endfunction

   // Transaction-level reference: returns the packet the requester should see and updates refMem
   task automatic refTxn(inout vec_t v);
      logic [DW-1:0] old;
      logic [DAW-1:0] a;
      v.expBad = (v.addr >= AW'(DS)) || (v.op > 3'd4);
      case (v.op)
         3'd0:             v.expType = v.ic ? 2'd3 : (v.fl ? 2'd2 : 2'd1);
         3'd2, 3'd3, 3'd4: v.expType = 2'd1;
         default:          v.expType = 2'd0;
      endcase
      v.expData = '0;
      if (!v.expBad) begin
         a   = v.addr[DAW-1:0];
         old = refMem[a];
         case (v.op)
            3'd0: v.expData = old;
            3'd1: for (int b = 0; b < MW; b++) if (v.mask[b]) refMem[a][8*b +: 8] = v.data[8*b +: 8];
            3'd2: begin v.expData = old; refMem[a] = v.data; end
            3'd3: begin v.expData = old; refMem[a] = old | v.data; end
            default: begin v.expData = old; refMem[a] = old + v.data; end
         endcase
      end
   endtask

   // Offers one request and runs it to the returned packet; starts and ends at a negedge
   task automatic applyStimulus(input vec_t v, input int grantPct, input int readyPct, output res_t r);
      bit accepted = 0;
      r = '{typ: '0, data: '0, rid: '0, x: '0, y: '0, badCyc: 0, dvCyc: 0, done: 1'b0};
      in_op_i = v.op; in_addr_i = v.addr; in_data_i = v.data; in_mask_i = v.mask;
      in_reg_id_i = v.rid; in_float_wb_i = v.fl; in_icache_fetch_i = v.ic;
      in_src_x_i = v.sx; in_src_y_i = v.sy; in_v_i = 1'b1;
      for (int cyc = 0; cyc < 300 && !r.done; cyc++) begin
         dmem_yumi_i = ($urandom_range(99) < grantPct);
         ret_ready_i = ($urandom_range(99) < readyPct);
         #1;
         if (bad_req_o) r.badCyc++;
         if (dmem_v_o) r.dvCyc++;
         if (in_v_i && in_yumi_o) accepted = 1;
         if (ret_v_o && ret_ready_i) begin
            r.done = 1'b1; r.typ = ret_pkt_type_o; r.data = ret_data_o;
            r.rid = ret_reg_id_o; r.x = ret_x_o; r.y = ret_y_o;
         end
         @(posedge clk_i); #1;
         if (accepted) in_v_i = 1'b0;
         @(negedge clk_i);
      end
      in_v_i = 1'b0; dmem_yumi_i = 1'b0; ret_ready_i = 1'b0;
   endtask

   task automatic runAndCheck(input string tag, input vec_t v, input int g, input int rd);
      res_t r;
      applyStimulus(v, g, rd, r);
      checkOutput({tag, " done"}, r.done, 1);
      checkOutput({tag, " type"}, r.typ, v.expType);
      checkOutput({tag, " data"}, r.data, v.expData);
      checkOutput({tag, " reg"}, r.rid, v.rid);
      checkOutput({tag, " x"}, r.x, v.sx);
      checkOutput({tag, " y"}, r.y, v.sy);
      checkOutput({tag, " badpulse"}, r.badCyc, v.expBad ? 1 : 0);
      if (v.expBad) checkOutput({tag, " dmem_v on bad"}, r.dvCyc, 0);
   endtask

   vec_t vecs[19];

   initial begin
      vec_t v, tmp;
      int wrBefore;
      for (int i = 0; i < DS; i++) refMem[i] = '0;
      vecs[0]  = mkVec(3'd1, 28'h10,  32'hDEADBEEF, 4'hF, 5'd3,  0, 0, 2'd0, 32'h0,        0);
      vecs[1]  = mkVec(3'd0, 28'h10,  32'h0,        4'h0, 5'd7,  1, 0, 2'd2, 32'hDEADBEEF, 0);
      vecs[2]  = mkVec(3'd1, 28'h20,  32'h1,        4'hF, 5'd1,  0, 0, 2'd0, 32'h0,        0);
      vecs[3]  = mkVec(3'd4, 28'h20,  32'hFFFFFFFF, 4'h0, 5'd9,  0, 0, 2'd1, 32'h1,        0);
      vecs[4]  = mkVec(3'd0, 28'h20,  32'h0,        4'h0, 5'd2,  0, 0, 2'd1, 32'h0,        0);
      vecs[5]  = mkVec(3'd1, 28'h30,  32'h00F,      4'hF, 5'd4,  0, 0, 2'd0, 32'h0,        0);
      vecs[6]  = mkVec(3'd3, 28'h30,  32'h0F0,      4'h0, 5'd5,  1, 1, 2'd1, 32'h00F,      0);
      vecs[7]  = mkVec(3'd0, 28'h30,  32'h0,        4'h0, 5'd6,  0, 1, 2'd3, 32'h0FF,      0);
      vecs[8]  = mkVec(3'd2, 28'h30,  32'h5,        4'h0, 5'd8,  0, 0, 2'd1, 32'h0FF,      0);
      vecs[9]  = mkVec(3'd0, 28'h30,  32'h0,        4'h0, 5'd10, 1, 1, 2'd3, 32'h5,        0);
      vecs[10] = mkVec(3'd1, 28'h40,  32'hAABBCCDD, 4'hF, 5'd11, 0, 0, 2'd0, 32'h0,        0);
      vecs[11] = mkVec(3'd1, 28'h40,  32'h11223344, 4'h5, 5'd12, 0, 0, 2'd0, 32'h0,        0);
      vecs[12] = mkVec(3'd0, 28'h40,  32'h0,        4'h0, 5'd13, 0, 0, 2'd1, 32'hAA22CC44, 0);
      vecs[13] = mkVec(3'd0, 28'h400, 32'h0,        4'h0, 5'd14, 0, 0, 2'd1, 32'h0,        1);
      vecs[14] = mkVec(3'd6, 28'h0,   32'h0,        4'hF, 5'd15, 0, 0, 2'd0, 32'h0,        1);
      vecs[15] = mkVec(3'd4, 28'hFFFFFFF, 32'h3,    4'h0, 5'd16, 0, 0, 2'd1, 32'h0,        1);
      vecs[16] = mkVec(3'd0, 28'h3FF, 32'h0,        4'h0, 5'd17, 0, 0, 2'd1, 32'h0,        0);
      vecs[17] = mkVec(3'd1, 28'h400, 32'h12345678, 4'hF, 5'd18, 0, 0, 2'd0, 32'h0,        1);
      vecs[18] = mkVec(3'd0, 28'h0,   32'h0,        4'h0, 5'd19, 0, 0, 2'd1, 32'h0,        0);

      reset_n_i = 1'b0; memClr = 1'b1;
      in_v_i = 1'b1; in_op_i = 3'd6; in_addr_i = '0; in_data_i = 32'hFFFFFFFF; in_mask_i = '1;
      in_reg_id_i = '0; in_float_wb_i = 0; in_icache_fetch_i = 0; in_src_x_i = '0; in_src_y_i = '0;
      dmem_yumi_i = 1'b1; ret_ready_i = 1'b1;
      repeat (2) @(negedge clk_i);
      #1;
      checkOutput("reset in_yumi", in_yumi_o, 0);
      checkOutput("reset bad_req", bad_req_o, 0);
      checkOutput("reset ret_v", ret_v_o, 0);
      in_op_i = 3'd1;
      #1;
      checkOutput("reset dmem_v", dmem_v_o, 0);
      checkOutput("reset dmem_data", dmem_data_o, 0);
      in_v_i = 1'b0; dmem_yumi_i = 1'b0; ret_ready_i = 1'b0;
      @(negedge clk_i);
      memClr = 1'b0; reset_n_i = 1'b1;
      @(negedge clk_i);

      $display("[TB] vector table");
      for (int i = 0; i < 19; i++) begin
         tmp = vecs[i];
         refTxn(tmp);
         runAndCheck($sformatf("vec%0d", i), vecs[i], 100, 100);
      end

      $display("[TB] store latency and held response");
      in_op_i = 3'd1; in_addr_i = 28'h50; in_data_i = 32'h13579BDF; in_mask_i = 4'hF;
      in_reg_id_i = 5'd3; in_float_wb_i = 0; in_icache_fetch_i = 0; in_src_x_i = 7'd2; in_src_y_i = 7'd5;
      in_v_i = 1'b1; dmem_yumi_i = 1'b1; ret_ready_i = 1'b0;
      #1;
      checkOutput("store yumi same cycle", in_yumi_o, 1);
      checkOutput("store dmem_w", dmem_w_o, 1);
      @(posedge clk_i); #1; in_v_i = 1'b0;
      @(negedge clk_i); #1;
      checkOutput("store ret_v next cycle", ret_v_o, 1);
      checkOutput("store ret type", ret_pkt_type_o, 0);
      checkOutput("store ret data", ret_data_o, 0);
      checkOutput("store ret xy", {ret_x_o, ret_y_o}, {7'd2, 7'd5});
      ret_ready_i = 1'b1;
      @(posedge clk_i); #1; ret_ready_i = 1'b0;
      tmp = mkVec(3'd1, 28'h50, 32'h13579BDF, 4'hF, 5'd3, 0, 0, 0, 0, 0); refTxn(tmp);
      @(negedge clk_i);

      in_op_i = 3'd0; in_addr_i = 28'h10; in_float_wb_i = 1; in_reg_id_i = 5'd7; in_v_i = 1'b1;
      @(posedge clk_i); #1; in_v_i = 1'b0; in_float_wb_i = 0;
      @(negedge clk_i); #1;
      checkOutput("load no ret in rd_wait", ret_v_o, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i); #1;
         checkOutput($sformatf("held%0d ret_v", k), ret_v_o, 1);
         checkOutput($sformatf("held%0d type", k), ret_pkt_type_o, 2);
         checkOutput($sformatf("held%0d data", k), ret_data_o, 32'hDEADBEEF);
         checkOutput($sformatf("held%0d reg", k), ret_reg_id_o, 7);
      end
      @(negedge clk_i); ret_ready_i = 1'b1;
      @(posedge clk_i); #1; ret_ready_i = 1'b0;
      @(negedge clk_i); #1;
      checkOutput("held ret_v cleared", ret_v_o, 0);
      dmem_yumi_i = 1'b0;

      $display("[TB] withheld grants");
      v = mkVec(3'd1, 28'h60, 32'h100, 4'hF, 5'd1, 0, 0, 2'd0, 32'h0, 0);
      tmp = v; refTxn(tmp);
      runAndCheck("pre-amo store", v, 100, 100);
      in_op_i = 3'd4; in_addr_i = 28'h60; in_data_i = 32'h23; in_reg_id_i = 5'd21;
      in_v_i = 1'b1; dmem_yumi_i = 1'b0; ret_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         checkOutput($sformatf("idle stall%0d yumi", k), in_yumi_o, 0);
         checkOutput($sformatf("idle stall%0d dmem_v", k), dmem_v_o, 1);
         checkOutput($sformatf("idle stall%0d addr", k), dmem_addr_o, 10'h60);
         @(negedge clk_i);
      end
      dmem_yumi_i = 1'b1; #1;
      checkOutput("amo accept yumi", in_yumi_o, 1);
      @(posedge clk_i); #1; in_v_i = 1'b0; dmem_yumi_i = 1'b0;
      @(negedge clk_i); #1;
      checkOutput("amo rd_wait dmem_v", dmem_v_o, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i); #1;
         checkOutput($sformatf("amo_wr stall%0d v/w", k), {dmem_v_o, dmem_w_o}, 2'b11);
         checkOutput($sformatf("amo_wr stall%0d data", k), dmem_data_o, 32'h123);
         checkOutput($sformatf("amo_wr stall%0d mask", k), dmem_mask_o, 4'hF);
         checkOutput($sformatf("amo_wr stall%0d addr", k), dmem_addr_o, 10'h60);
         checkOutput($sformatf("amo_wr stall%0d ret_v", k), ret_v_o, 0);
      end
      dmem_yumi_i = 1'b1;
      @(posedge clk_i); #1; dmem_yumi_i = 1'b0;
      @(negedge clk_i); #1;
      checkOutput("amo ret_v", ret_v_o, 1);
      checkOutput("amo ret type", ret_pkt_type_o, 1);
      checkOutput("amo ret old data", ret_data_o, 32'h100);
      checkOutput("amo written data", lastWrData, 32'h123);
      checkOutput("amo written mask", lastWrMask, 4'hF);
      tmp = mkVec(3'd4, 28'h60, 32'h23, 4'h0, 5'd21, 0, 0, 0, 0, 0); refTxn(tmp);
      @(negedge clk_i); ret_ready_i = 1'b0;

      $display("[TB] reset during amo write");
      in_op_i = 3'd2; in_addr_i = 28'h70; in_data_i = 32'hCAFEF00D; in_v_i = 1'b1; dmem_yumi_i = 1'b1;
      @(posedge clk_i); #1; in_v_i = 1'b0; dmem_yumi_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i); #1;
      checkOutput("in amo_wr before reset", dmem_v_o, 1);
      wrBefore = wrCount;
      in_v_i = 1'b1; in_op_i = 3'd6; dmem_yumi_i = 1'b1; ret_ready_i = 1'b1;
      reset_n_i = 1'b0; #1;
      checkOutput("mid reset dmem_v", dmem_v_o, 0);
      checkOutput("mid reset dmem_w", dmem_w_o, 0);
      checkOutput("mid reset dmem_addr", dmem_addr_o, 0);
      checkOutput("mid reset dmem_data", dmem_data_o, 0);
      checkOutput("mid reset yumi", in_yumi_o, 0);
      checkOutput("mid reset bad_req", bad_req_o, 0);
      checkOutput("mid reset ret_v", ret_v_o, 0);
      checkOutput("mid reset ret fields", {ret_pkt_type_o, ret_reg_id_o, ret_x_o, ret_y_o}, 0);
      in_v_i = 1'b0; in_op_i = 3'd1;
      @(negedge clk_i); reset_n_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checkOutput($sformatf("post reset%0d dmem_v", k), dmem_v_o, 0);
         checkOutput($sformatf("post reset%0d ret_v", k), ret_v_o, 0);
         @(negedge clk_i);
      end
      dmem_yumi_i = 1'b0; ret_ready_i = 1'b0;
      checkOutput("no write after reset", wrCount - wrBefore, 0);
      runAndCheck("post reset load", mkVec(3'd0, 28'h70, 0, 0, 5'd22, 0, 0, 2'd1, 32'h0, 0), 100, 100);
      v = mkVec(3'd1, 28'h70, 32'h5A5A5A5A, 4'hF, 5'd23, 0, 0, 2'd0, 32'h0, 0);
      tmp = v; refTxn(tmp);
      runAndCheck("post reset store", v, 100, 100);
      runAndCheck("post reset readback", mkVec(3'd0, 28'h70, 0, 0, 5'd24, 0, 0, 2'd1, 32'h5A5A5A5A, 0), 100, 100);

      $display("[TB] random requests");
      for (int n = 0; n < 150; n++) begin
         int r = $urandom_range(15);
         v.op   = (r < 14) ? 3'(r % 5) : 3'(5 + (r % 3));
         v.addr = ($urandom_range(15) == 0) ? AW'(DS + $urandom_range(200)) : AW'(256 + $urandom_range(15));
         v.data = $urandom; v.mask = 4'($urandom_range(15)); v.rid = 5'($urandom_range(31));
         v.fl = 1'($urandom_range(1)); v.ic = 1'($urandom_range(1));
         v.sx = 7'($urandom_range(127)); v.sy = 7'($urandom_range(127));
         refTxn(v);
         runAndCheck($sformatf("rand%0d", n), v, 60, 60);
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
